// File: rtl/iommu_ds_mem_responder.sv
// AXI4 slave word memory that terminates the IOMMU data-structure master port.
// Independent read and write FSMs share one array; a backdoor port preloads and inspects it.
module iommu_ds_mem_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH = 4,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ar_valid_i,
  output logic                       ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]      ar_addr_i,
  input  logic [ID_WIDTH-1:0]        ar_id_i,
  input  logic [7:0]                 ar_len_i,
  input  logic [1:0]                 ar_burst_i,
  output logic                       r_valid_o,
  input  logic                       r_ready_i,
  output logic [DATA_WIDTH-1:0]      r_data_o,
  output logic [ID_WIDTH-1:0]        r_id_o,
  output logic [1:0]                 r_resp_o,
  output logic                       r_last_o,
  input  logic                       aw_valid_i,
  output logic                       aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]      aw_addr_i,
  input  logic [ID_WIDTH-1:0]        aw_id_i,
  input  logic [7:0]                 aw_len_i,
  input  logic [1:0]                 aw_burst_i,
  input  logic                       w_valid_i,
  output logic                       w_ready_o,
  input  logic [DATA_WIDTH-1:0]      w_data_i,
  input  logic [DATA_WIDTH/8-1:0]    w_strb_i,
  input  logic                       w_last_i,
  output logic                       b_valid_o,
  input  logic                       b_ready_i,
  output logic [ID_WIDTH-1:0]        b_id_o,
  output logic [1:0]                 b_resp_o,
  input  logic                       bd_we_i,
  input  logic [$clog2(DEPTH)-1:0]   bd_addr_i,
  input  logic [DATA_WIDTH-1:0]      bd_wdata_i,
  output logic [DATA_WIDTH-1:0]      bd_rdata_o,
  output logic                       bd_ready_o
);

  localparam int IDX_WIDTH = $clog2(DEPTH);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] addr);
    return (addr - BASE_ADDR) >> BYTE_SHIFT;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >= BASE_ADDR) && (word_of(addr) < ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IDX_WIDTH-1:0] mem_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_WIDTH'(word_of(addr));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [1:0] burst);
    return (burst == BURST_INCR) ? addr + ADDR_WIDTH'(STRB_WIDTH) : addr;
  endfunction

  r_state_t r_state, r_state_n;
  logic [ADDR_WIDTH-1:0] r_addr, rd_addr_sel;
  logic [7:0] r_len, r_beat;
  logic [1:0] r_burst, rd_burst_sel, rd_resp_sel;
  logic rd_start, rd_load;
  logic [DATA_WIDTH-1:0] rd_data_sel;

  assign ar_ready_o = (r_state == R_IDLE);
  assign r_valid_o = (r_state == R_BURST);

  always_comb begin
    r_state_n = r_state;
    rd_start = 1'b0;
    rd_load = 1'b0;
    rd_addr_sel = next_addr(r_addr, r_burst);
    rd_burst_sel = r_burst;
    case (r_state)
      R_IDLE: if (ar_valid_i) begin
        r_state_n = R_BURST;
        rd_start = 1'b1;
        rd_load = 1'b1;
        rd_addr_sel = ar_addr_i;
        rd_burst_sel = ar_burst_i;
      end
      R_BURST: if (r_ready_i) begin
        if (r_beat == r_len) r_state_n = R_IDLE;
        else rd_load = 1'b1;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Beat data is captured into registers so it stays stable under backpressure even if the word is rewritten.
  always_comb begin
    rd_data_sel = '0;
    rd_resp_sel = RESP_OKAY;
    if (!addr_ok(rd_addr_sel)) rd_resp_sel = RESP_DECERR;
    else if (rd_burst_sel != BURST_FIXED && rd_burst_sel != BURST_INCR) rd_resp_sel = RESP_SLVERR;
    else rd_data_sel = mem[mem_idx(rd_addr_sel)];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      r_addr <= '0;
      r_len <= '0;
      r_beat <= '0;
      r_burst <= '0;
      r_data_o <= '0;
      r_id_o <= '0;
      r_resp_o <= '0;
      r_last_o <= 1'b0;
    end else begin
      r_state <= r_state_n;
      if (rd_start) begin
        r_id_o <= ar_id_i;
        r_len <= ar_len_i;
        r_burst <= ar_burst_i;
        r_beat <= '0;
        r_last_o <= (ar_len_i == 8'd0);
      end else if (rd_load) begin
        r_beat <= r_beat + 8'd1;
        r_last_o <= (r_beat + 8'd1 == r_len);
      end
      if (rd_load) begin
        r_addr <= rd_addr_sel;
        r_data_o <= rd_data_sel;
        r_resp_o <= rd_resp_sel;
      end
    end
  end

  w_state_t w_state, w_state_n;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0] w_len, w_beat;
  logic [1:0] w_burst, w_resp_n;
  logic w_dec, w_over, w_fire, w_beat_ok, w_burst_ok, wr_en;

  assign aw_ready_o = (w_state == W_IDLE);
  assign w_ready_o = (w_state == W_DATA);
  assign b_valid_o = (w_state == W_RESP);
  assign w_fire = (w_state == W_DATA) && w_valid_i;
  assign w_beat_ok = addr_ok(w_addr);
  assign w_burst_ok = (w_burst == BURST_FIXED) || (w_burst == BURST_INCR);
  assign wr_en = w_fire && w_beat_ok && w_burst_ok;
  assign bd_ready_o = !w_fire;

  // w_over remembers a beat at index len that was not last, so a long burst cannot alias back to OKAY.
  always_comb begin
    w_state_n = w_state;
    w_resp_n = RESP_OKAY;
    if (w_dec || !w_beat_ok) w_resp_n = RESP_DECERR;
    else if (!w_burst_ok || w_over || (w_beat != w_len)) w_resp_n = RESP_SLVERR;
    case (w_state)
      W_IDLE: if (aw_valid_i) w_state_n = W_DATA;
      W_DATA: if (w_valid_i && w_last_i) w_state_n = W_RESP;
      W_RESP: if (b_ready_i) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      w_addr <= '0;
      w_len <= '0;
      w_beat <= '0;
      w_burst <= '0;
      w_dec <= 1'b0;
      w_over <= 1'b0;
      b_id_o <= '0;
      b_resp_o <= '0;
    end else begin
      w_state <= w_state_n;
      if (w_state == W_IDLE && aw_valid_i) begin
        w_addr <= aw_addr_i;
        w_len <= aw_len_i;
        w_burst <= aw_burst_i;
        w_beat <= '0;
        w_dec <= 1'b0;
        w_over <= 1'b0;
        b_id_o <= aw_id_i;
      end else if (w_fire) begin
        w_addr <= next_addr(w_addr, w_burst);
        w_beat <= w_beat + 8'd1;
        w_dec <= w_dec | !w_beat_ok;
        w_over <= w_over | (w_beat == w_len);
        if (w_last_i) b_resp_o <= w_resp_n;
      end
    end
  end

  // Single array write port: an AXI beat always wins over the backdoor.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (w_strb_i[b]) mem[mem_idx(w_addr)][8*b +: 8] <= w_data_i[8*b +: 8];
    end else if (bd_we_i && bd_ready_o) begin
      mem[bd_addr_i] <= bd_wdata_i;
    end
  end

  assign bd_rdata_o = mem[bd_addr_i];

endmodule

// File: tb/tb_iommu_ds_mem_responder.sv
// Self-checking bench for iommu_ds_mem_responder: directed scenarios then randomized bursts
// compared against a word-array reference model.
module tb_iommu_ds_mem_responder;

  localparam int DEPTH = 64;
  localparam logic [63:0] BASE = 64'h1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ar_valid = 0, ar_ready, r_valid, r_ready = 0, r_last;
  logic [63:0] ar_addr = '0, r_data;
  logic [3:0] ar_id = '0, r_id;
  logic [7:0] ar_len = '0;
  logic [1:0] ar_burst = '0, r_resp;
  logic aw_valid = 0, aw_ready, w_valid = 0, w_ready, w_last = 0, b_valid, b_ready = 0;
  logic [63:0] aw_addr = '0, w_data = '0;
  logic [3:0] aw_id = '0, b_id;
  logic [7:0] aw_len = '0, w_strb = '0;
  logic [1:0] aw_burst = '0, b_resp;
  logic bd_we = 0, bd_ready;
  logic [5:0] bd_addr = '0;
  logic [63:0] bd_wdata = '0, bd_rdata;

  logic [63:0] model [DEPTH];
  int checks = 0;
  int errors = 0;

  iommu_ds_mem_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4), .DEPTH(DEPTH),
                           .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr), .ar_id_i(ar_id),
    .ar_len_i(ar_len), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_id_o(r_id),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr), .aw_id_i(aw_id),
    .aw_len_i(aw_len), .aw_burst_i(aw_burst),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
    .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata), .bd_rdata_o(bd_rdata),
    .bd_ready_o(bd_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_map(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) / 8 < DEPTH);
  endfunction

  function automatic int model_idx(input logic [63:0] a);
    return int'((a - BASE) / 8);
  endfunction

  // Byte address of beat k, computed directly rather than by stepping.
  function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [1:0] burst, input int k);
    return (burst == 2'b01) ? a + 64'(8 * k) : a;
  endfunction

  task automatic bd_write(input int idx, input logic [63:0] val);
    bd_we = 1'b1;
    bd_addr = 6'(idx);
    bd_wdata = val;
    #1;
    check_output("bd_ready_idle", bd_ready, 1);
    tick();
    bd_we = 1'b0;
    model[idx] = val;
  endtask

  task automatic bd_check(input string tag, input int idx);
    bd_addr = 6'(idx);
    #1;
    check_output(tag, bd_rdata, model[idx]);
  endtask

  task automatic read_burst(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input logic [1:0] burst, input int mode);
    logic [63:0] exp_data [$];
    logic [1:0] exp_resp [$];
    logic [63:0] a;
    int beat = 0;
    int cyc = 0;
    int budget = 20;
    while (!ar_ready && budget > 0) begin
      tick();
      budget--;
    end
    check_output("ar_ready_wait", ar_ready, 1);
    for (int k = 0; k <= int'(len); k++) begin
      a = beat_addr(addr, burst, k);
      if (!in_map(a)) begin
        exp_data.push_back(64'h0);
        exp_resp.push_back(2'b11);
      end else if (burst > 2'b01) begin
        exp_data.push_back(64'h0);
        exp_resp.push_back(2'b10);
      end else begin
        exp_data.push_back(model[model_idx(a)]);
        exp_resp.push_back(2'b00);
      end
    end
    ar_valid = 1'b1;
    ar_addr = addr;
    ar_len = len;
    ar_id = id;
    ar_burst = burst;
    tick();
    ar_valid = 1'b0;
    while (beat <= int'(len) && cyc < 400) begin
      r_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      check_output("r_valid", r_valid, 1);
      check_output("r_data", r_data, exp_data[beat]);
      check_output("r_resp", r_resp, exp_resp[beat]);
      check_output("r_last", r_last, beat == int'(len));
      check_output("r_id", r_id, id);
      check_output("ar_ready_busy", ar_ready, 0);
      tick();
      cyc++;
      if (r_ready) beat++;
    end
    r_ready = 1'b0;
    check_output("r_beats_done", 64'(beat), 64'(int'(len) + 1));
    check_output("r_valid_after", r_valid, 0);
    check_output("ar_ready_after", ar_ready, 1);
  endtask

  task automatic write_burst(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input logic [1:0] burst, input int nbeats, input bit gaps,
                             input bit use_fixed, input logic [63:0] fdata, input logic [7:0] fstrb,
                             input int contend_idx);
    logic [63:0] a, d;
    logic [7:0] s;
    logic [1:0] exp_resp;
    bit dec = 0;
    int budget = 20;
    while (!aw_ready && budget > 0) begin
      tick();
      budget--;
    end
    check_output("aw_ready_wait", aw_ready, 1);
    aw_valid = 1'b1;
    aw_addr = addr;
    aw_len = len;
    aw_id = id;
    aw_burst = burst;
    tick();
    aw_valid = 1'b0;
    check_output("aw_ready_busy", aw_ready, 0);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        w_valid = 1'b0;
        #1;
        check_output("bd_ready_gap", bd_ready, 1);
        tick();
      end
      d = use_fixed ? fdata : {$urandom(), $urandom()};
      s = use_fixed ? fstrb : 8'($urandom());
      w_valid = 1'b1;
      w_data = d;
      w_strb = s;
      w_last = (k == nbeats - 1);
      if (k == 0 && contend_idx >= 0) begin
        bd_we = 1'b1;
        bd_addr = 6'(contend_idx);
        bd_wdata = ~model[contend_idx];
      end
      #1;
      check_output("w_ready", w_ready, 1);
      check_output("bd_ready_busy", bd_ready, 0);
      tick();
      bd_we = 1'b0;
      a = beat_addr(addr, burst, k);
      if (!in_map(a)) dec = 1;
      else if (burst <= 2'b01)
        for (int b = 0; b < 8; b++)
          if (s[b]) model[model_idx(a)][8*b +: 8] = d[8*b +: 8];
    end
    w_valid = 1'b0;
    w_last = 1'b0;
    exp_resp = dec ? 2'b11 : (burst > 2'b01 || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
    check_output("b_valid", b_valid, 1);
    check_output("b_id", b_id, id);
    check_output("b_resp", b_resp, exp_resp);
    check_output("aw_ready_in_resp", aw_ready, 0);
    if ($urandom_range(0, 1) == 1) begin
      tick();
      check_output("b_valid_hold", b_valid, 1);
      check_output("b_resp_hold", b_resp, exp_resp);
    end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check_output("b_valid_after", b_valid, 0);
    check_output("aw_ready_after", aw_ready, 1);
  endtask

  initial begin
    int off, nb;
    logic [1:0] bst;
    logic [7:0] ln;
    logic [63:0] ad;
    $display("[TB] start");
    tick();
    tick();
    check_output("rst_ar_ready", ar_ready, 1);
    check_output("rst_aw_ready", aw_ready, 1);
    check_output("rst_r_valid", r_valid, 0);
    check_output("rst_w_ready", w_ready, 0);
    check_output("rst_b_valid", b_valid, 0);
    check_output("rst_r_data", r_data, 0);
    check_output("rst_r_last", r_last, 0);
    check_output("rst_b_resp", b_resp, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) bd_write(i, {$urandom(), $urandom()});

    // Single-beat read of a preloaded word.
    bd_write(16, 64'hDEADBEEF01234567);
    read_burst(BASE + 64'h80, 8'd0, 4'd3, 2'b01, 0);

    // Four-beat INCR read with r_ready toggling 1,0,0,1,...
    for (int i = 0; i < 4; i++) bd_write(32 + i, 64'(i + 1));
    read_burst(BASE + 64'h100, 8'd3, 4'd5, 2'b01, 1);

    // Partial strobe write.
    bd_write(48, 64'hFFFF_FFFF_FFFF_FFFF);
    write_burst(BASE + 64'h180, 8'd0, 4'd2, 2'b01, 1, 0, 1, 64'h0, 8'h0F, -1);
    bd_check("bd_strobe_merge", 48);
    check_output("strobe_value", model[48], 64'hFFFFFFFF00000000);

    // Error responses.
    read_burst(BASE + 64'(DEPTH * 8), 8'd1, 4'd7, 2'b01, 0);
    read_burst(BASE + 64'h8, 8'd0, 4'd1, 2'b10, 0);
    read_burst(BASE + 64'h8, 8'd2, 4'd1, 2'b10, 2);
    read_burst(BASE - 64'h8, 8'd1, 4'd9, 2'b00, 0);
    write_burst(BASE + 64'h40, 8'd2, 4'd4, 2'b01, 2, 0, 0, '0, '0, -1);
    write_burst(BASE + 64'h40, 8'd1, 4'd6, 2'b01, 2, 0, 0, '0, '0, -1);
    write_burst(BASE + 64'h20, 8'd0, 4'd8, 2'b10, 1, 0, 0, '0, '0, -1);
    write_burst(BASE + 64'(DEPTH * 8 - 8), 8'd1, 4'd3, 2'b01, 2, 0, 0, '0, '0, -1);
    bd_check("bd_after_err", 4);

    // Backdoor loses to a concurrent AXI beat.
    write_burst(BASE + 64'h38, 8'd0, 4'd2, 2'b01, 1, 0, 0, '0, '0, 9);
    bd_check("bd_contend_dropped", 9);
    bd_check("bd_contend_axi", 7);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      off = int'($urandom_range(0, DEPTH + 3)) - 2;
      ad = BASE + 64'(off * 8) + 64'($urandom_range(0, 7));
      nb = int'($urandom_range(0, 9));
      bst = (nb < 2) ? 2'b00 : (nb < 9) ? 2'b01 : 2'b10;
      ln = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) begin
        read_burst(ad, ln, 4'($urandom()), bst, 2);
      end else begin
        nb = ($urandom_range(0, 4) == 0) ? int'(ln) + int'($urandom_range(0, 2)) : int'(ln) + 1;
        if (nb < 1) nb = 1;
        write_burst(ad, ln, 4'($urandom()), bst, nb, 1, 0, '0, '0, -1);
      end
      if ($urandom_range(0, 3) == 0) bd_write(int'($urandom_range(0, DEPTH - 1)), {$urandom(), $urandom()});
      bd_check("bd_random", int'($urandom_range(0, DEPTH - 1)));
    end

    // Reset in the middle of a read burst.
    bd_write(5, 64'hA5A5_5A5A_0F0F_F0F0);
    ar_valid = 1'b1;
    ar_addr = BASE + 64'h28;
    ar_len = 8'd3;
    ar_burst = 2'b01;
    ar_id = 4'd2;
    tick();
    ar_valid = 1'b0;
    check_output("pre_rst_r_valid", r_valid, 1);
    check_output("pre_rst_r_data", r_data, model[5]);
    rst = 1'b1;
    #1;
    check_output("mid_rst_r_valid", r_valid, 0);
    check_output("mid_rst_ar_ready", ar_ready, 1);
    check_output("mid_rst_r_data", r_data, 0);
    tick();
    rst = 1'b0;
    tick();
    check_output("post_rst_r_valid", r_valid, 0);
    for (int i = 0; i < 8; i++) bd_check("post_rst_mem", i);
    read_burst(BASE + 64'h28, 8'd1, 4'd2, 2'b01, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
